// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: shares one 16x2 LCD driver between N_REQ message sources.
// Arbitrates level requests, latches the winner's two 128-bit lines, pulses
// ack/update for one cycle, then holds the display for HOLD_CYC cycles.
// Build option: define LCD_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// index wins) instead of the default round robin.
module lcd_msg_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_CYC = 12500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*128-1:0]   line1_in,
  input  logic [N_REQ*128-1:0]   line2_in,
  output logic [N_REQ-1:0]       ack,
  output logic [127:0]           line1,
  output logic [127:0]           line2,
  output logic                   update,
  output logic [1:0]             owner,
  output logic                   busy
);

  localparam int unsigned CW       = $clog2(HOLD_CYC + 1);
  localparam int unsigned IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [127:0]  BLANK    = {16{8'h20}};

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [127:0]      line1_q;
  logic [127:0]      line2_q;
  logic              update_q;
  logic [1:0]        owner_q;
  logic              busy_q;

`ifndef LCD_SCHED_FIXED_PRIO_EN
  logic [1:0]        ptr_q;
  logic [1:0]        ptr_d;
  localparam logic [1:0] LAST_IDX = 2'(N_REQ - 1);
`endif

  logic              any_d;
  logic [1:0]        win_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [127:0]      line1_d;
  logic [127:0]      line2_d;

  // Pick the winner: first set req bit scanning upward from the start index.
  always_comb begin
    int unsigned idx;
    any_d = 1'b0;
    win_d = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef LCD_SCHED_FIXED_PRIO_EN
      idx = k;
`else
      // Rotate from the pointer; one conditional subtract replaces a modulo.
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
`endif
      if (!any_d && req[IW'(idx)]) begin
        any_d = 1'b1;
        win_d = 2'(idx);
      end
    end
  end

  // Route the winner's text and build its one-hot acknowledge.
  always_comb begin
    gnt_d   = '0;
    line1_d = BLANK;
    line2_d = BLANK;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (2'(j) == win_d) begin
        gnt_d[j] = 1'b1;
        line1_d  = line1_in[128*j +: 128];
        line2_d  = line2_in[128*j +: 128];
      end
    end
  end

`ifndef LCD_SCHED_FIXED_PRIO_EN
  // Round-robin pointer advances past the winner, wrapping at N_REQ-1.
  always_comb begin
    ptr_d = (win_d == LAST_IDX) ? 2'd0 : win_d + 2'd1;
  end
`endif

  // Grant/hold FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= '0;
      update_q <= 1'b0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      line1_q  <= BLANK;
      line2_q  <= BLANK;
`ifndef LCD_SCHED_FIXED_PRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      ack_q    <= '0;
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            ack_q    <= gnt_d;
            update_q <= 1'b1;
            owner_q  <= win_d;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_LOAD;
`ifndef LCD_SCHED_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack    = ack_q;
  assign line1  = line1_q;
  assign line2  = line2_q;
  assign update = update_q;
  assign owner  = owner_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Bench for lcd_msg_scheduler (N_REQ=4, HOLD_CYC=8): stimulus process feeds
// a reference model that queues expected grants; a monitor pops and compares.
module tb_lcd_msg_scheduler;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*128-1:0] l1_in = '0;
  logic [N*128-1:0] l2_in = '0;
  logic [N-1:0]     ack;
  logic [127:0]     line1;
  logic [127:0]     line2;
  logic             update;
  logic [1:0]       owner;
  logic             busy;

  lcd_msg_scheduler #(.N_REQ(N), .HOLD_CYC(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .line1_in (l1_in),
    .line2_in (l2_in),
    .ack      (ack),
    .line1    (line1),
    .line2    (line2),
    .update   (update),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           w;
    logic [127:0] t1;
    logic [127:0] t2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   in_rst = 1'b1;
  int   free_cyc = 0;
  int   rr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: a grant is possible once HOLD+1 cycles have passed since the
  // previous one; the winner is the first requester in arbitration order.
  function automatic void model(int c);
    int w;
    int j;
    w = -1;
    if (c < free_cyc || req == '0) return;
    for (int k = 0; k < N; k++) begin
`ifdef LCD_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = (rr + k) % N;
`endif
      if (w < 0 && ((req >> j) & 4'd1) != 4'd0) w = j;
    end
    q.push_back('{c, w, l1_in[w*128 +: 128], l2_in[w*128 +: 128]});
    free_cyc = c + HOLD + 1;
    rr = (w + 1) % N;
  endfunction

  // One cycle of stimulus, applied just after the falling edge.
  task automatic drive(input logic [N-1:0] r, input bit do_rst);
    @(negedge clk);
    #2;
    rst    = do_rst;
    in_rst = do_rst;
    if (do_rst) begin
      q.delete();
      free_cyc = 0;
      rr = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (((r >> i) & 4'd1) == 4'd0) begin
        l1_in[i*128 +: 128] = rnd128();
        l2_in[i*128 +: 128] = rnd128();
      end
    end
    req = r;
    if (!do_rst) model(cyc + 1);
  endtask

  // Monitor: pops the expected grant when due, otherwise expects quiet outputs.
  logic [127:0] exp_l1 = BLANK;
  logic [127:0] exp_l2 = BLANK;
  int           exp_owner = 0;
  int           busy_until = 0;

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] oh;
    if (in_rst) begin
      exp_l1 = BLANK;
      exp_l2 = BLANK;
      exp_owner = 0;
      busy_until = 0;
      chk("rst_ack", 128'(ack), 128'(0));
      chk("rst_update", 128'(update), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_owner", 128'(owner), 128'(0));
      chk("rst_line1", line1, BLANK);
      chk("rst_line2", line2, BLANK);
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e  = q.pop_front();
        oh = 4'b0001 << e.w;
        chk("grant_ack", 128'(ack), 128'(oh));
        chk("grant_update", 128'(update), 128'(1));
        exp_l1 = e.t1;
        exp_l2 = e.t2;
        exp_owner = e.w;
        busy_until = cyc + HOLD;
      end else begin
        chk("idle_ack", 128'(ack), 128'(0));
        chk("idle_update", 128'(update), 128'(0));
      end
      chk("line1", line1, exp_l1);
      chk("line2", line2, exp_l2);
      chk("owner", 128'(owner), 128'(exp_owner));
      chk("busy", 128'(busy), 128'(cyc < busy_until));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    // Reset and 20 quiet cycles.
    repeat (3) drive('0, 1'b1);
    repeat (20) drive('0, 1'b0);

    // Single request from source 2 with a known text.
    l1_in[2*128 +: 128] = {"SRC2", {12{8'h20}}};
    l2_in[2*128 +: 128] = {"LINE", {12{8'h20}}};
    drive(4'b0100, 1'b0);
    repeat (12) drive('0, 1'b0);

    // Contention from a fresh pointer: expect 0,1,2,3,0 spaced 9 cycles.
    repeat (2) drive('0, 1'b1);
    repeat (40) drive(4'b1111, 1'b0);
    repeat (12) drive('0, 1'b0);

    // Request raised during the hold of source 1.
    drive(4'b0010, 1'b0);
    repeat (2) drive('0, 1'b0);
    repeat (12) drive(4'b1000, 1'b0);
    repeat (8) drive('0, 1'b0);

    // Reset four cycles into a hold, with req[0] pending across it.
    drive(4'b0001, 1'b0);
    repeat (3) drive('0, 1'b0);
    drive(4'b0001, 1'b1);
    #1;
    chk("rst_now_busy", 128'(busy), 128'(0));
    chk("rst_now_line1", line1, BLANK);
    chk("rst_now_ack", 128'(ack), 128'(0));
    repeat (2) drive(4'b0001, 1'b1);
    drive(4'b0001, 1'b0);
    repeat (12) drive('0, 1'b0);

    // Fixed-priority style stress: 4'b1011 held then req[0] dropped.
    repeat (30) drive(4'b1011, 1'b0);
    repeat (20) drive(4'b1010, 1'b0);
    repeat (12) drive('0, 1'b0);

    // Random requests, including withdrawals and held requests.
    r = '0;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r = r ^ (4'b0001 << b);
      end
      drive(r, 1'b0);
    end
    repeat (12) drive('0, 1'b0);

    chk("scoreboard_empty", 128'(q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
